// File: rtl/tone_pkg.sv
// tone_pkg: shared state encoding, note word types and clock-divider helper for the tone player
package tone_pkg;
    localparam int FREQ_W = 32;
    localparam int DUR_W = 16;
    typedef enum logic {IDLE, PLAY} tone_state_t;
    typedef logic [FREQ_W-1:0] freq_t;
    typedef logic [DUR_W-1:0] dur_t;
    function automatic int ms_div(input int fclk);
        return fclk / 1000;
    endfunction
endpackage

// File: rtl/tone_chan.sv
// tone_chan: one channel's note FSM, remainder-preserving phase accumulator and ms timer
module tone_chan import tone_pkg::*; #(
    parameter int FCLK = 50_000_000,
    parameter int FW = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    input  logic [FW-1:0] freq,
    input  logic [DW-1:0] dur_ms,
    output logic          busy,
    output logic          done,
    output logic          tone_out
);
    localparam int MSD = ms_div(FCLK);
    localparam int SW = $clog2(MSD + 1);
    localparam logic [FW+1:0] FC = (FW+2)'(FCLK);
    localparam logic [SW-1:0] SUB_TOP = SW'(MSD - 1);

    tone_state_t   state_q;
    logic [FW-1:0] freq_q;
    logic [DW-1:0] ms_q;
    logic [SW-1:0] sub_q;
    logic [FW+1:0] acc_q;
    logic          tone_q;
    logic          done_q;
    logic [FW+1:0] step_d;
    logic [FW+1:0] sum_d;
    logic          big_d;
    logic          wrap_d;
    logic          fin_d;

    // step = 2*freq; a step at or above FCLK means toggling every cycle
    always_comb begin
        step_d = {1'b0, freq_q, 1'b0};
        sum_d = acc_q + step_d;
        big_d = step_d >= FC;
        wrap_d = sum_d >= FC;
        fin_d = ms_q == DW'(1) && sub_q == '0;
    end

    // accept in IDLE, toggle on accumulator wrap, return to IDLE on timeout or stop with a done pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            freq_q <= '0;
            ms_q <= '0;
            sub_q <= '0;
            acc_q <= '0;
            tone_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start && !stop) begin
                    state_q <= PLAY;
                    freq_q <= freq;
                    ms_q <= dur_ms;
                    sub_q <= SUB_TOP;
                    acc_q <= '0;
                    tone_q <= 1'b0;
                end
            end else if (stop || fin_d) begin
                state_q <= IDLE;
                acc_q <= '0;
                tone_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                if (big_d) begin
                    acc_q <= '0;
                    tone_q <= ~tone_q;
                end else if (wrap_d) begin
                    acc_q <= sum_d - FC;
                    tone_q <= ~tone_q;
                end else begin
                    acc_q <= sum_d;
                end
                if (sub_q == '0) begin
                    sub_q <= SUB_TOP;
                    if (ms_q != '0) ms_q <= ms_q - DW'(1);
                end else begin
                    sub_q <= sub_q - SW'(1);
                end
            end
        end
    end

    assign busy = state_q == PLAY;
    assign done = done_q;
    assign tone_out = tone_q;
endmodule

// File: rtl/tone_player.sv
// tone_player: NCH independent tone channels merged onto one speaker line by highest-index priority
module tone_player import tone_pkg::*; #(
    parameter int FCLK = 50_000_000,
    parameter int NCH = 2,
    parameter int FW = 32,
    parameter int DW = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NCH-1:0]          start,
    input  logic [NCH-1:0]          stop,
    input  logic [NCH-1:0][FW-1:0]  freq,
    input  logic [NCH-1:0][DW-1:0]  dur_ms,
    output logic [NCH-1:0]          busy,
    output logic [NCH-1:0]          done,
    output logic [NCH-1:0]          tone_out,
    output logic                    mix_out
);
    logic mix_q;
    logic mix_d;

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_chan
            tone_chan #(.FCLK(FCLK), .FW(FW), .DW(DW)) u_chan (
                .clk(clk),
                .reset_n(reset_n),
                .start(start[i]),
                .stop(stop[i]),
                .freq(freq[i]),
                .dur_ms(dur_ms[i]),
                .busy(busy[i]),
                .done(done[i]),
                .tone_out(tone_out[i])
            );
        end
    endgenerate

    // later (higher-index) busy channels override earlier ones
    always_comb begin
        mix_d = 1'b0;
        for (int k = 0; k < NCH; k++) mix_d = busy[k] ? tone_out[k] : mix_d;
    end

    // register the merged speaker line
    always_ff @(posedge clk) begin
        if (!reset_n) mix_q <= 1'b0;
        else mix_q <= mix_d;
    end

    assign mix_out = mix_q;
endmodule
